// File: rtl/jk_down_cnt.sv
// jk_down_cnt: presettable synchronous down counter / programmable divider.
// A preset N is accepted through a valid/ready handshake while idle. The
// counter then steps N..1 on enabled clocks and emits a registered one-cycle
// tc pulse on the clock that follows the edge which consumed q==1. With
// AUTO_RELOAD set it reloads N and keeps running (divide-by-N); otherwise it
// returns to IDLE with q=0 (one-shot timer).
// The decrement uses the JK toggle form: bit i toggles when every lower bit
// is 0, which mirrors the toggle-chain up counter this block pairs with.

module jk_down_cnt #(
  parameter int WIDTH       = 4,
  parameter int AUTO_RELOAD = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             stop,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_val,
  output logic             load_ready,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             tc
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  logic             state;
  logic [WIDTH-1:0] reload;
  logic [WIDTH-1:0] q_dec;
  logic             zero_below;
  logic             q_is_one;
  logic             load_zero;

  // Toggle-chain decrement: a running "all lower bits are zero" flag
  // decides which bits flip, so no adder or subtractor is inferred.
  always_comb begin
    q_dec      = '0;
    zero_below = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      q_dec[i]   = q[i] ^ zero_below;
      zero_below = zero_below & ~q[i];
    end
  end

  assign q_is_one   = (q == WIDTH'(1));
  assign load_zero  = (load_val == '0);
  assign load_ready = (state == ST_IDLE);
  assign busy       = (state == ST_RUN);

  // Main sequencer: handshake-driven load while idle; in RUN, stop beats
  // the enable gate, which beats counting and terminal-count handling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      q      <= '0;
      reload <= '0;
      tc     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          tc <= 1'b0;
          if (load_valid) begin
            if (load_zero) begin
              q  <= '0;
              tc <= 1'b1;
            end else begin
              q      <= load_val;
              reload <= load_val;
              state  <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          tc <= 1'b0;
          if (stop) begin
            state <= ST_IDLE;
          end else if (en) begin
            if (q_is_one) begin
              tc <= 1'b1;
              if (AUTO_RELOAD != 0) begin
                q <= reload;
              end else begin
                q     <= '0;
                state <= ST_IDLE;
              end
            end else begin
              q <= q_dec;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          tc    <= 1'b0;
        end
      endcase
    end
  end

endmodule
